// File: rtl/dpram_clr.sv
// Dual-port RAM: port 0 read-only, port 1 read/write with byte-lane enables.
// A clear engine sweeps every word to IV after reset or on a CLR pulse.
module dpram_clr #(
  parameter int              AW = 8,
  parameter int              DW = 8,
  parameter logic [DW-1:0]   IV = '0,
  parameter bit              WT = 1'b0
) (
  input  logic               CL,
  input  logic               RESET,
  input  logic               CLR,
  output logic               BUSY,
  input  logic [AW-1:0]      AD0,
  input  logic               EN0,
  output logic [DW-1:0]      RD0,
  input  logic [AW-1:0]      AD1,
  input  logic               EN1,
  input  logic               WE1,
  input  logic [DW/8-1:0]    BE1,
  input  logic [DW-1:0]      WD1,
  output logic [DW-1:0]      RD1
);

  localparam int          NB    = DW / 8;
  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] LAST  = (AW+1)'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          state;
  logic [AW:0]     cnt;
  logic [DW-1:0]   mem [DEPTH] = '{default: IV};

  logic            wr_ok;
  logic [DW-1:0]   merged;
  logic [NB-1:0]   mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;

  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_word,
                                                input logic [DW-1:0] new_word,
                                                input logic [NB-1:0] be);
    logic [DW-1:0] w;
    w = old_word;
    for (int i = 0; i < NB; i++)
      if (be[i]) w[8*i +: 8] = new_word[8*i +: 8];
    return w;
  endfunction

  // A CLR edge already belongs to the sweep, so user writes are refused on it too.
  assign wr_ok  = !RESET && !CLR && (state == S_IDLE) && EN1 && WE1;
  assign merged = merge_lanes(mem[AD1], WD1, BE1);
  assign BUSY   = (state == S_CLEAR);

  always_comb begin
    mem_be    = '0;
    mem_addr  = AD1;
    mem_wdata = WD1;
    if (!RESET && !CLR && state == S_CLEAR) begin
      mem_be    = '1;
      mem_addr  = cnt[AW-1:0];
      mem_wdata = IV;
    end else if (wr_ok) begin
      mem_be    = BE1;
    end
  end

  always_ff @(posedge CL) begin
    for (int i = 0; i < NB; i++)
      if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  always_ff @(posedge CL) begin
    if (RESET) begin
      state <= S_CLEAR;
      cnt   <= '0;
      RD0   <= '0;
      RD1   <= '0;
    end else begin
      if (CLR) begin
        state <= S_CLEAR;
        cnt   <= '0;
      end else if (state == S_CLEAR) begin
        cnt <= cnt + ONE;
        if (cnt == LAST) state <= S_IDLE;
      end

      // While sweeping, reads report the fill value even for words not yet reached.
      if (EN0) begin
        if (state == S_CLEAR)                RD0 <= IV;
        else if (WT && wr_ok && AD0 == AD1)  RD0 <= merged;
        else                                 RD0 <= mem[AD0];
      end

      if (EN1 && !WE1) begin
        if (state == S_CLEAR) RD1 <= IV;
        else                  RD1 <= mem[AD1];
      end
    end
  end

endmodule

// File: tb/tb_dpram_clr.sv
// Bench for dpram_clr: two instances (old-data and write-through collision modes)
// share stimulus and are checked against a word-level reference model.
module tb_dpram_clr;

  localparam int          AW = 4;
  localparam int          DW = 16;
  localparam logic [15:0] IV = 16'hA5A5;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, en0, en1, we1;
  logic [3:0]  ad0, ad1;
  logic [1:0]  be1;
  logic [15:0] wd1;
  logic        busy_a, busy_b;
  logic [15:0] rd0_a, rd1_a, rd0_b, rd1_b;

  dpram_clr #(.AW(AW), .DW(DW), .IV(IV), .WT(1'b0)) dut_a (
    .CL(clk), .RESET(rst), .CLR(clr), .BUSY(busy_a),
    .AD0(ad0), .EN0(en0), .RD0(rd0_a),
    .AD1(ad1), .EN1(en1), .WE1(we1), .BE1(be1), .WD1(wd1), .RD1(rd1_a));

  dpram_clr #(.AW(AW), .DW(DW), .IV(IV), .WT(1'b1)) dut_b (
    .CL(clk), .RESET(rst), .CLR(clr), .BUSY(busy_b),
    .AD0(ad0), .EN0(en0), .RD0(rd0_b),
    .AD1(ad1), .EN1(en1), .WE1(we1), .BE1(be1), .WD1(wd1), .RD1(rd1_b));

  int checks = 0;
  int failures = 0;

  // Reference model: a sweep is seen as "all words become IV at once, reads
  // return IV and writes are ignored for the next 16 edges".
  logic [15:0] m_mem [16];
  int          m_left = 0;
  logic [15:0] e_rd0_a = '0, e_rd0_b = '0, e_rd1 = '0;

  task automatic tick();
    bit          busy_now, wr;
    logic [15:0] nw;
    busy_now = (m_left > 0);
    nw = m_mem[ad1];
    for (int i = 0; i < 2; i++)
      if (be1[i]) nw[8*i +: 8] = wd1[8*i +: 8];
    wr = !rst && !busy_now && !clr && en1 && we1;
    if (rst) begin
      m_left = 16;
      e_rd0_a = '0; e_rd0_b = '0; e_rd1 = '0;
      foreach (m_mem[i]) m_mem[i] = IV;
    end else begin
      if (en0) begin
        e_rd0_a = busy_now ? IV : m_mem[ad0];
        e_rd0_b = busy_now ? IV : ((wr && ad0 == ad1) ? nw : m_mem[ad0]);
      end
      if (en1 && !we1) e_rd1 = busy_now ? IV : m_mem[ad1];
      if (wr) m_mem[ad1] = nw;
      if (clr) begin
        m_left = 16;
        foreach (m_mem[i]) m_mem[i] = IV;
      end else if (busy_now) begin
        m_left--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; clr = 1'b0; en0 = 1'b0; en1 = 1'b0; we1 = 1'b0;
    ad0 = '0; ad1 = '0; be1 = '0; wd1 = '0;
  endtask

  task automatic write1(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    en1 = 1'b1; we1 = 1'b1; ad1 = a; wd1 = d; be1 = be;
    tick();
    en1 = 1'b0; we1 = 1'b0;
  endtask

  task automatic read1(input logic [3:0] a);
    en1 = 1'b1; we1 = 1'b0; ad1 = a;
    tick();
    en1 = 1'b0;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy_a === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL reset_busy actual=%b expected=1", busy_a); end
    checks++; if (rd0_a !== 16'h0) begin failures++; $display("FAIL reset_rd0 actual=%h expected=0000", rd0_a); end
    checks++; if (rd1_a !== 16'h0) begin failures++; $display("FAIL reset_rd1 actual=%h expected=0000", rd1_a); end
    checks++; if (rd0_b !== 16'h0) begin failures++; $display("FAIL reset_rd0_wt actual=%h expected=0000", rd0_b); end
    wait_sweep(n);
    checks++; if (n != 16) begin failures++; $display("FAIL reset_busy_len actual=%0d expected=16", n); end
    checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL reset_busy_wt actual=%b expected=0", busy_b); end
    for (int a = 0; a < 16; a++) begin
      en0 = 1'b1; ad0 = 4'(a);
      tick();
      checks++;
      if (rd0_a !== 16'hA5A5 || rd0_a !== e_rd0_a || rd0_b !== 16'hA5A5) begin
        failures++;
        $display("FAIL fill_read addr=%0d actual=%h/%h expected=a5a5", a, rd0_a, rd0_b);
      end
    end
    en0 = 1'b0;
  endtask

  task automatic test_byte_enables();
    write1(4'd3, 16'h1234, 2'b01);
    write1(4'd3, 16'hABCD, 2'b10);
    read1(4'd3);
    checks++;
    if (rd1_a !== 16'hAB34 || rd1_a !== e_rd1 || rd1_b !== 16'hAB34) begin
      failures++; $display("FAIL byte_lanes actual=%h/%h expected=ab34", rd1_a, rd1_b);
    end
    write1(4'd3, 16'hFFFF, 2'b00);
    read1(4'd3);
    checks++;
    if (rd1_a !== 16'hAB34 || rd1_b !== 16'hAB34) begin
      failures++; $display("FAIL be_zero actual=%h/%h expected=ab34", rd1_a, rd1_b);
    end
  endtask

  task automatic test_collision();
    write1(4'd5, 16'h0000, 2'b11);
    read1(4'd3);
    en0 = 1'b1; ad0 = 4'd5;
    en1 = 1'b1; we1 = 1'b1; ad1 = 4'd5; wd1 = 16'hFFFF; be1 = 2'b11;
    tick();
    en0 = 1'b0; en1 = 1'b0; we1 = 1'b0;
    checks++; if (rd0_a !== 16'h0000) begin failures++; $display("FAIL collision_old actual=%h expected=0000", rd0_a); end
    checks++; if (rd0_b !== 16'hFFFF) begin failures++; $display("FAIL collision_wt actual=%h expected=ffff", rd0_b); end
    checks++;
    if (rd1_a !== 16'hAB34 || rd1_b !== 16'hAB34) begin
      failures++; $display("FAIL collision_rd1_hold actual=%h/%h expected=ab34", rd1_a, rd1_b);
    end
    en0 = 1'b1; ad0 = 4'd5;
    tick();
    en0 = 1'b0;
    checks++; if (rd0_a !== 16'hFFFF) begin failures++; $display("FAIL collision_stored actual=%h expected=ffff", rd0_a); end
  endtask

  task automatic test_clear_restart();
    int n;
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (6) tick();
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL restart_busy_mid actual=%b expected=1", busy_a); end
    clr = 1'b1; tick(); clr = 1'b0;
    write1(4'd7, 16'h1111, 2'b11);
    wait_sweep(n);
    n = n + 1;
    checks++; if (n != 16) begin failures++; $display("FAIL restart_busy_len actual=%0d expected=16", n); end
    read1(4'd7);
    checks++;
    if (rd1_a !== 16'hA5A5 || rd1_a !== e_rd1) begin
      failures++; $display("FAIL dropped_write actual=%h expected=a5a5", rd1_a);
    end
  endtask

  task automatic test_enables_reset();
    int n;
    write1(4'd2, 16'h0F0F, 2'b11);
    en0 = 1'b1; ad0 = 4'd2; tick(); en0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ad0 = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if (rd0_a !== 16'h0F0F || rd0_a !== e_rd0_a) begin
        failures++; $display("FAIL en0_hold cyc=%0d actual=%h expected=0f0f", i, rd0_a);
      end
    end
    clr = 1'b1; tick(); clr = 1'b0;
    en0 = 1'b1; en1 = 1'b1; we1 = 1'b0; ad0 = 4'd1; ad1 = 4'd2;
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    en0 = 1'b0; en1 = 1'b0;
    checks++;
    if (rd0_a !== 16'h0 || rd1_a !== 16'h0 || rd0_b !== 16'h0 || rd1_b !== 16'h0) begin
      failures++; $display("FAIL midsweep_reset_rd actual=%h/%h expected=0000", rd0_a, rd1_a);
    end
    wait_sweep(n);
    checks++; if (n != 16) begin failures++; $display("FAIL midsweep_reset_len actual=%0d expected=16", n); end
  endtask

  task automatic test_reads_during_clear();
    int n;
    write1(4'd9, 16'h5555, 2'b11);
    en0 = 1'b1; ad0 = 4'd9; en1 = 1'b1; we1 = 1'b0; ad1 = 4'd9;
    tick();
    checks++;
    if (rd0_a !== 16'h5555 || rd1_a !== 16'h5555) begin
      failures++; $display("FAIL pre_clear_read actual=%h/%h expected=5555", rd0_a, rd1_a);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    tick();
    checks++;
    if (rd0_a !== 16'hA5A5 || rd1_a !== 16'hA5A5 || rd0_b !== 16'hA5A5) begin
      failures++; $display("FAIL clear_read actual=%h/%h expected=a5a5", rd0_a, rd1_a);
    end
    en0 = 1'b0; en1 = 1'b0;
    wait_sweep(n);
    read1(4'd9);
    checks++; if (rd1_a !== 16'hA5A5) begin failures++; $display("FAIL cleared_word actual=%h expected=a5a5", rd1_a); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      clr = ($urandom_range(0, 59) == 0);
      en0 = 1'($urandom_range(0, 1));
      en1 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      ad1 = 4'($urandom_range(0, 15));
      ad0 = ($urandom_range(0, 2) == 0) ? ad1 : 4'($urandom_range(0, 15));
      be1 = 2'($urandom_range(0, 3));
      wd1 = 16'($urandom);
      tick();
      checks++;
      if (busy_a !== (m_left > 0) || busy_b !== (m_left > 0)) begin
        failures++; $display("FAIL rand_busy cyc=%0d actual=%b/%b expected=%b", c, busy_a, busy_b, m_left > 0);
      end
      checks++;
      if (rd0_a !== e_rd0_a) begin failures++; $display("FAIL rand_rd0 cyc=%0d actual=%h expected=%h", c, rd0_a, e_rd0_a); end
      checks++;
      if (rd0_b !== e_rd0_b) begin failures++; $display("FAIL rand_rd0_wt cyc=%0d actual=%h expected=%h", c, rd0_b, e_rd0_b); end
      checks++;
      if (rd1_a !== e_rd1 || rd1_b !== e_rd1) begin
        failures++; $display("FAIL rand_rd1 cyc=%0d actual=%h/%h expected=%h", c, rd1_a, rd1_b, e_rd1);
      end
    end
    idle_inputs();
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = IV;
    idle_inputs();
    test_reset();
    test_byte_enables();
    test_collision();
    test_clear_restart();
    test_enables_reset();
    test_reads_during_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpram_clr.md
# dpram_clr

Parametrised dual-port RAM: port 0 read-only, port 1 read/write with byte-lane write enables, and a built-in clear engine that sweeps the whole array to a fill value after reset or on request. Next-generation replacement for the plain dual-port and initialised single-port RAMs in the arcade cores. Intended for work RAM, video RAM and sprite RAM that must return to a known state on every core reset without reloading the FPGA.

## Interface
- AW, 8: address width; depth = 2^AW words
- DW, 8: data width; must be a multiple of 8; NB = DW/8 byte lanes
- IV, 0: fill value written by the clear engine (DW bits)
- WT, 0: port-0 collision mode; 0 = old data, 1 = write-through (new data)

Ports:
- CL  in  1  clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- CLR  in  1  single-cycle request to start a clear sweep
- BUSY  out  1  clear sweep in progress
- AD0  in  AW  port-0 address
- EN0  in  1  port-0 read enable
- RD0  out  DW  port-0 registered read data
- AD1  in  AW  port-1 address
- EN1  in  1  port-1 enable
- WE1  in  1  port-1 write (qualified by EN1)
- BE1  in  NB  port-1 byte enables; lane i = bits [8i+7:8i]
- WD1  in  DW  port-1 write data
- RD1  out  DW  port-1 registered read data

## Operation
- States: CLEAR (BUSY=1) and IDLE (BUSY=0). Sweep counter CNT, AW+1 bits.
- RESET high at an edge: state←CLEAR, CNT←0, RD0←0, RD1←0. Nothing is written while RESET is high.
- CLEAR, RESET low: write IV to address CNT[AW-1:0], CNT←CNT+1. The write to address 2^AW−1 is the last; the same edge moves the state to IDLE.
- CLR high in IDLE or CLEAR: state←CLEAR, CNT←0 (a sweep in progress restarts from 0). RESET has priority over CLR.
- Port 0, EN0=1: RD0←mem[AD0]. EN0=0: RD0 holds.
- Port 1, EN1=1, WE1=0: RD1←mem[AD1].
- Port 1, EN1=1, WE1=1: each lane with BE1[i]=1 takes WD1 lane i; other lanes are unchanged. RD1 holds. BE1=0 writes nothing.
- Collision (EN0, EN1, WE1 all high, AD0=AD1): with WT=0, RD0 gets the pre-write word. With WT=1, RD0 gets the merged post-write word.
- During CLEAR, user writes are dropped and not queued. An enabled read on either port loads IV into its RD register, regardless of how far the sweep has progressed.
- Array contents at power-up are IV; a RESET sweep then makes them IV again.

## Timing
- Read latency 1 cycle: address at edge n, data valid after edge n.
- BUSY is registered. It goes high on the edge that samples RESET or CLR. It stays high for exactly 2^AW edges after RESET/CLR is released, then drops.
- The first user write accepted is on the edge after BUSY is seen low.
- Port 1 does not forward write data to RD1.
- Output reset values: RD0=0, RD1=0, BUSY=1.

## Test plan
- AW=4, DW=16, IV=16'hA5A5. Hold RESET 3 cycles, release. Expected: BUSY=1 for exactly 16 cycles after release; then a port-0 read of every address returns 16'hA5A5.
- Byte enables. Write address 3 with WD1=16'h1234, BE1=2'b01; then write 16'hABCD with BE1=2'b10. Expected: a port-1 read of address 3 returns 16'hAB34. BE1=0 leaves the word unchanged.
- Collision. Address 5 holds 16'h0000. Write 16'hFFFF to address 5 while port 0 reads address 5 in the same cycle. Expected: RD0=16'h0000 with WT=0, 16'hFFFF with WT=1. RD1 holds its previous value.
- Clear restart. Pulse CLR, then pulse CLR again 7 cycles later. Expected: BUSY stays high for 16 cycles after the second pulse. A port-1 write issued during the sweep is dropped; address reads back 16'hA5A5 afterward.
- Enables and reset. With EN0=0, change AD0 each cycle. Expected: RD0 holds. Assert RESET mid-sweep. Expected: RD0=RD1=0, and the sweep restarts from address 0 for a full 16 cycles.
- Reads during CLEAR. Write 16'h5555 to address 9, then pulse CLR. Read address 9 on both ports during the sweep. Expected: both ports return 16'hA5A5.
